// File: rtl/drain_counter.sv
// Bounded down-counter: drains x from the bound n to 0, one unit per accepted step,
// optionally capturing the pre-decrement index, then re-arms through a valid/ready load.
module drain_counter #(
    parameter int WIDTH  = 16,
    parameter int INIT_N = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             selector,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_n,
    output logic             load_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] cap_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        ST_DRAIN = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_N);
    localparam state_t INIT_STATE = (INIT_V != '0) ? ST_DRAIN : ST_DONE;
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    state_t state_reg, state_next;
    logic [WIDTH-1:0] x_reg, x_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic [WIDTH-1:0] n_reg, n_next;
    logic [WIDTH-1:0] cap_reg, cap_next;
    logic dec, cap, load;

    // Steps only count in DRAIN and loads only in DONE, so the two never collide.
    always_comb begin
        dec  = (state_reg == ST_DRAIN) && step;
        cap  = dec && selector;
        load = (state_reg == ST_DONE) && load_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= INIT_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (dec && (x_reg == ONE_V)) begin
            state_next = ST_DONE;
        end
        if (load && (load_n != '0)) begin
            state_next = ST_DRAIN;
        end
    end

    always_comb begin
        busy       = (state_reg == ST_DRAIN);
        done       = (state_reg == ST_DONE);
        load_ready = (state_reg == ST_DONE);
    end

    always_comb begin
        x_next   = x_reg;
        m_next   = m_reg;
        n_next   = n_reg;
        cap_next = cap_reg;
        if (dec) begin
            x_next = x_reg - ONE_V;
        end
        if (cap) begin
            m_next   = x_reg;
            cap_next = cap_reg + ONE_V;
        end
        if (load) begin
            n_next   = load_n;
            x_next   = load_n;
            m_next   = load_n;
            cap_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg   <= INIT_V;
            m_reg   <= INIT_V;
            n_reg   <= INIT_V;
            cap_reg <= '0;
        end else begin
            x_reg   <= x_next;
            m_reg   <= m_next;
            n_reg   <= n_next;
            cap_reg <= cap_next;
        end
    end

    assign x       = x_reg;
    assign m       = m_reg;
    assign n       = n_reg;
    assign cap_cnt = cap_reg;

    // Safety invariants on the registered state; the capture rule means m==0 implies no capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_x_le_n: assert (x_reg <= n_reg);
            a_m_le_n: assert (m_reg <= n_reg);
            a_x_le_m: assert (x_reg <= m_reg);
            a_cap_le: assert (cap_reg <= (n_reg - x_reg));
            a_cap_nz: assert (!((x_reg == '0) && (n_reg != '0) && (m_reg == '0) && (cap_reg != '0)));
            a_done:   assert ((state_reg == ST_DONE) == (x_reg == '0));
        end
    end

endmodule
